// File: rtl/font_rom_arbiter_pkg.sv
// Shared definitions for the font ROM arbiter: owner encodings, default widths and the tag layout.
package font_rom_arbiter_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 8;
    localparam int WAIT_W     = 4;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/font_rom_arbiter_tag_pipe.sv
// Ownership pipe for outstanding font ROM reads: DEPTH stages of {vld, owner}, asynchronously cleared.
module font_arb_tag_pipe
    import font_rom_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_vld,
    input  logic in_owner,
    output logic tap_vld,
    output logic tap_owner,
    output logic out_vld,
    output logic out_owner
);

    tag_t stage_reg [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= '{vld: in_vld, owner: owner_e'(in_owner)};
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    // The tap stage lines up with rom_data; the last stage lines up with the registered outputs.
    assign tap_vld   = stage_reg[DEPTH-2].vld;
    assign tap_owner = stage_reg[DEPTH-2].owner;
    assign out_vld   = stage_reg[DEPTH-1].vld;
    assign out_owner = stage_reg[DEPTH-1].owner;

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-port arbiter sharing one synchronous font ROM; round-robin by default,
// strict A priority with a B starvation guard when FONT_ARB_PRIO_EN is defined.
module font_rom_arbiter
    import font_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ROM_LAT  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              gnt_a,
    output logic              valid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              gnt_b,
    output logic              valid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int DEPTH = ROM_LAT + 1;

    generate
        if (ROM_LAT < 1 || MAX_WAIT < 1 || MAX_WAIT > (1 << WAIT_W) - 1) begin : g_bad_params
            $error("font_rom_arbiter: ROM_LAT must be >= 1 and MAX_WAIT must fit the wait counter");
        end
    endgenerate

    logic   sel_a;
    logic   sel_b;
    owner_e grant_owner;
    logic   tap_vld;
    logic   tap_owner;
    logic   out_vld;
    logic   out_owner;
    logic [DATA_W-1:0] rdata_a_reg;
    logic [DATA_W-1:0] rdata_b_reg;

`ifdef FONT_ARB_PRIO_EN
    logic [WAIT_W-1:0] wait_reg;
    logic [WAIT_W-1:0] wait_next;
    logic              starved;

    assign starved = (wait_reg == WAIT_W'(MAX_WAIT));

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (!reset) begin
            if (req_b && starved) begin
                sel_b = 1'b1;
            end else if (req_a) begin
                sel_a = 1'b1;
            end else if (req_b) begin
                sel_b = 1'b1;
            end
        end
    end

    // Counts only cycles where B is actually left waiting; saturates rather than wrapping.
    always_comb begin
        wait_next = wait_reg;
        if (!req_b || sel_b) begin
            wait_next = '0;
        end else if (wait_reg != '1) begin
            wait_next = wait_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_reg <= '0;
        end else begin
            wait_reg <= wait_next;
        end
    end
`else
    owner_e last_reg;
    owner_e last_next;

    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (!reset) begin
            if (req_a && req_b) begin
                if (last_reg == OWN_B) begin
                    sel_a = 1'b1;
                end else begin
                    sel_b = 1'b1;
                end
            end else begin
                sel_a = req_a;
                sel_b = req_b;
            end
        end
    end

    always_comb begin
        last_next = last_reg;
        if (sel_a) begin
            last_next = OWN_A;
        end else if (sel_b) begin
            last_next = OWN_B;
        end
    end

    // Reset value OWN_B makes the first contended grant go to A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= OWN_B;
        end else begin
            last_reg <= last_next;
        end
    end
`endif

    assign gnt_a       = sel_a;
    assign gnt_b       = sel_b;
    assign grant_owner = sel_b ? OWN_B : OWN_A;

    always_comb begin
        rom_addr = '0;
        if (sel_a) begin
            rom_addr = addr_a;
        end else if (sel_b) begin
            rom_addr = addr_b;
        end
    end

    font_arb_tag_pipe #(
        .DEPTH(DEPTH)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (sel_a | sel_b),
        .in_owner  (grant_owner),
        .tap_vld   (tap_vld),
        .tap_owner (tap_owner),
        .out_vld   (out_vld),
        .out_owner (out_owner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else if (tap_vld) begin
            if (tap_owner == OWN_A) begin
                rdata_a_reg <= rom_data;
            end else begin
                rdata_b_reg <= rom_data;
            end
        end
    end

    assign rdata_a = rdata_a_reg;
    assign rdata_b = rdata_b_reg;
    assign valid_a = out_vld && (out_owner == OWN_A);
    assign valid_b = out_vld && (out_owner == OWN_B);

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed and scoreboarded checks of font_rom_arbiter against a 1-cycle ROM model (data = addr[7:0] ^ 8'hA5).
module tb_font_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b;
    logic [10:0] addr_a, addr_b;
    logic        gnt_a, gnt_b, valid_a, valid_b;
    logic [7:0]  rdata_a, rdata_b;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_addr[7:0] ^ 8'hA5;

    font_rom_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req_a    (req_a),
        .addr_a   (addr_a),
        .gnt_a    (gnt_a),
        .valid_a  (valid_a),
        .rdata_a  (rdata_a),
        .req_b    (req_b),
        .addr_b   (addr_b),
        .gnt_b    (gnt_b),
        .valid_b  (valid_b),
        .rdata_b  (rdata_b),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk11(input string tag, input logic [10:0] obs, input logic [10:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        addr_a = '0;
        addr_b = '0;
        step();
        reset  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        e_a, e_b, ev_a, ev_b, a_turn;
        logic [10:0] e_addr;
        logic [7:0]  exp_ra, exp_rb;
        logic        h_vld [2];
        logic        h_own [2];
        logic [7:0]  h_dat [2];
        logic        m_last_b;
        logic [3:0]  m_wait;
        int          nva, nvb;

        // Reset with both requests high: nothing may leak out
        reset  = 1'b1;
        req_a  = 1'b1;
        addr_a = 11'h041;
        req_b  = 1'b1;
        addr_b = 11'h7FF;
        step();
        step();
        mid();
        chk1("rst_gnt_a", gnt_a, 1'b0);
        chk1("rst_gnt_b", gnt_b, 1'b0);
        chk11("rst_rom_addr", rom_addr, 11'h000);
        chk1("rst_valid_a", valid_a, 1'b0);
        chk1("rst_valid_b", valid_b, 1'b0);
        chk8("rst_rdata_a", rdata_a, 8'h00);
        chk8("rst_rdata_b", rdata_b, 8'h00);
        step();
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        addr_a = '0;
        addr_b = '0;
        mid();
        chk11("idle_rom_addr", rom_addr, 11'h000);
        chk1("idle_gnt_a", gnt_a, 1'b0);
        step();

        // Single A read of 0x041
        req_a  = 1'b1;
        addr_a = 11'h041;
        mid();
        chk1("t1_gnt_a", gnt_a, 1'b1);
        chk1("t1_gnt_b", gnt_b, 1'b0);
        chk11("t1_rom_addr", rom_addr, 11'h041);
        step();
        req_a  = 1'b0;
        addr_a = '0;
        mid();
        chk1("t1_valid_a_early", valid_a, 1'b0);
        chk11("t1_rom_addr_idle", rom_addr, 11'h000);
        step();
        mid();
        chk1("t1_valid_a", valid_a, 1'b1);
        chk8("t1_rdata_a", rdata_a, 8'hE4);
        chk1("t1_valid_b", valid_b, 1'b0);
        step();
        mid();
        chk1("t1_valid_a_off", valid_a, 1'b0);
        chk8("t1_rdata_a_hold", rdata_a, 8'hE4);
        step();

        // B alone reads 0x7FF three cycles in a row
        for (int k = 0; k < 5; k++) begin
            req_b  = (k < 3);
            addr_b = (k < 3) ? 11'h7FF : 11'h000;
            mid();
            chk1("t4_gnt_b", gnt_b, (k < 3));
            chk1("t4_gnt_a", gnt_a, 1'b0);
            chk1("t4_valid_b", valid_b, (k >= 2));
            if (k >= 2) chk8("t4_rdata_b", rdata_b, 8'h5A);
            chk8("t4_rdata_a", rdata_a, 8'hE4);
            step();
        end

`ifndef FONT_ARB_PRIO_EN
        // Both ports contend for 8 cycles: strict alternation starting with A
        do_reset();
        nva = 0;
        nvb = 0;
        for (int k = 0; k < 10; k++) begin
            req_a  = (k < 8);
            req_b  = (k < 8);
            addr_a = 11'h080 + 11'(k);
            addr_b = 11'h0C0 + 11'(k);
            mid();
            if (k < 8) begin
                a_turn = (k % 2 == 0);
                chk1("t2_gnt_a", gnt_a, a_turn);
                chk1("t2_gnt_b", gnt_b, !a_turn);
                chk11("t2_rom_addr", rom_addr, a_turn ? addr_a : addr_b);
            end
            if (k >= 2) begin
                a_turn = ((k - 2) % 2 == 0);
                chk1("t2_valid_a", valid_a, a_turn);
                chk1("t2_valid_b", valid_b, !a_turn);
                if (a_turn) chk8("t2_rdata_a", rdata_a, (8'h80 + 8'(k - 2)) ^ 8'hA5);
                else        chk8("t2_rdata_b", rdata_b, (8'hC0 + 8'(k - 2)) ^ 8'hA5);
            end
            if (valid_a) nva++;
            if (valid_b) nvb++;
            step();
        end
        chk32("t2_count_a", nva, 4);
        chk32("t2_count_b", nvb, 4);
`else
        // Strict A priority: B wins only once its wait reaches 15
        do_reset();
        for (int k = 0; k < 20; k++) begin
            req_a  = 1'b1;
            req_b  = 1'b1;
            addr_a = 11'h041;
            addr_b = 11'h7FF;
            mid();
            chk1("t5_gnt_b", gnt_b, (k == 15));
            chk1("t5_gnt_a", gnt_a, (k != 15));
            chk1("t5_valid_b", valid_b, (k == 17));
            step();
        end
`endif

        // Reset right after a grant kills the in-flight read
        do_reset();
        req_a  = 1'b1;
        addr_a = 11'h010;
        mid();
        chk1("t3_gnt_a", gnt_a, 1'b1);
        step();
        reset  = 1'b1;
        req_a  = 1'b0;
        addr_a = '0;
        mid();
        chk1("t3_rst_gnt_a", gnt_a, 1'b0);
        chk1("t3_rst_gnt_b", gnt_b, 1'b0);
        chk1("t3_rst_valid_a", valid_a, 1'b0);
        chk1("t3_rst_valid_b", valid_b, 1'b0);
        chk8("t3_rst_rdata_a", rdata_a, 8'h00);
        chk8("t3_rst_rdata_b", rdata_b, 8'h00);
        chk11("t3_rst_rom_addr", rom_addr, 11'h000);
        step();
        reset = 1'b0;
        mid();
        chk1("t3_no_valid_a_1", valid_a, 1'b0);
        chk8("t3_rdata_a_1", rdata_a, 8'h00);
        step();
        mid();
        chk1("t3_no_valid_a_2", valid_a, 1'b0);
        step();

        // Random traffic against a reference grant model and response scoreboard
        do_reset();
        m_last_b = 1'b1;
        m_wait   = 4'd0;
        exp_ra   = 8'h00;
        exp_rb   = 8'h00;
        for (int i = 0; i < 2; i++) begin
            h_vld[i] = 1'b0;
            h_own[i] = 1'b0;
            h_dat[i] = 8'h00;
        end
        for (int k = 0; k < 2000; k++) begin
            req_a  = 1'($urandom_range(0, 1));
            req_b  = 1'($urandom_range(0, 1));
            addr_a = 11'($urandom);
            addr_b = 11'($urandom);
            e_a = 1'b0;
            e_b = 1'b0;
`ifdef FONT_ARB_PRIO_EN
            if (req_b && m_wait == 4'd15) e_b = 1'b1;
            else if (req_a)               e_a = 1'b1;
            else if (req_b)               e_b = 1'b1;
`else
            if (req_a && req_b) begin
                e_a = m_last_b;
                e_b = !m_last_b;
            end else begin
                e_a = req_a;
                e_b = req_b;
            end
`endif
            e_addr = e_a ? addr_a : (e_b ? addr_b : 11'h000);
            mid();
            chk1("r_gnt_a", gnt_a, e_a);
            chk1("r_gnt_b", gnt_b, e_b);
            chk1("r_gnt_excl", gnt_a && gnt_b, 1'b0);
            chk11("r_rom_addr", rom_addr, e_addr);
            ev_a = h_vld[1] && !h_own[1];
            ev_b = h_vld[1] && h_own[1];
            if (ev_a) exp_ra = h_dat[1];
            if (ev_b) exp_rb = h_dat[1];
            chk1("r_valid_a", valid_a, ev_a);
            chk1("r_valid_b", valid_b, ev_b);
            chk8("r_rdata_a", rdata_a, exp_ra);
            chk8("r_rdata_b", rdata_b, exp_rb);
            h_vld[1] = h_vld[0];
            h_own[1] = h_own[0];
            h_dat[1] = h_dat[0];
            h_vld[0] = e_a || e_b;
            h_own[0] = e_b;
            h_dat[0] = e_addr[7:0] ^ 8'hA5;
`ifdef FONT_ARB_PRIO_EN
            if (!req_b || e_b)       m_wait = 4'd0;
            else if (m_wait != 4'hF) m_wait = m_wait + 4'd1;
`else
            if (e_a)      m_last_b = 1'b0;
            else if (e_b) m_last_b = 1'b1;
`endif
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
